// File: rtl/energy_mean_divider_pkg.sv
// Shared definitions for the energy mean divider stage:
// FSM state encoding, default widths and end-to-end latency.
package energy_mean_divider_pkg;

    localparam int DATA_WIDTH  = 64;
    localparam int N_WIDTH     = 32;
    localparam int DIV_LATENCY = DATA_WIDTH + 3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DIV  = 2'd2,
        S_FIX  = 2'd3
    } state_t;

endpackage

// File: rtl/energy_mean_divider_seq_udiv.sv
// Bit-serial unsigned restoring divider, one quotient bit per clock.
// Ports: i_start loads operands; o_done pulses with o_quotient valid.
module seq_udiv #(
    parameter int DW = 64,
    parameter int NW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_start,
    input  logic [DW-1:0] i_dividend,
    input  logic [NW-1:0] i_divisor,
    output logic [DW-1:0] o_quotient,
    output logic          o_done
);

    localparam int CW = $clog2(DW);

    logic [NW:0]   r_rem;
    logic [DW-1:0] r_quo;
    logic [NW-1:0] r_div;
    logic [CW-1:0] r_cnt;
    logic          r_run;
    logic          r_done;

    logic [NW:0]   w_shift;
    logic [NW:0]   w_dvs;
    logic          w_ge;

    // The dividend shifts out of r_quo's MSB while quotient
    // bits shift in at the LSB, so one register holds both.
    assign w_shift = {r_rem[NW-1:0], r_quo[DW-1]};
    assign w_dvs   = {1'b0, r_div};
    assign w_ge    = (w_shift >= w_dvs);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rem  <= '0;
            r_quo  <= '0;
            r_div  <= '0;
            r_cnt  <= '0;
            r_run  <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (i_start) begin
                r_rem <= '0;
                r_quo <= i_dividend;
                r_div <= i_divisor;
                r_cnt <= CW'(DW - 1);
                r_run <= 1'b1;
            end else if (r_run) begin
                r_rem <= w_ge ? (w_shift - w_dvs) : w_shift;
                r_quo <= {r_quo[DW-2:0], w_ge};
                if (r_cnt == '0) begin
                    r_run  <= 1'b0;
                    r_done <= 1'b1;
                end else begin
                    r_cnt <= r_cnt - 1'b1;
                end
            end
        end
    end

    assign o_quotient = r_quo;
    assign o_done     = r_done;

endmodule

// File: rtl/energy_mean_divider.sv
// Mean power = signed energy / (sample count - N_OFFSET), serial divide.
// Ports: in_valid/in_energy/in_n request; out_* result pulse; busy, overrun.
module energy_mean_divider #(
    parameter int DATA_WIDTH = energy_mean_divider_pkg::DATA_WIDTH,
    parameter int N_WIDTH    = energy_mean_divider_pkg::N_WIDTH,
    parameter int N_OFFSET   = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    input  logic signed [DATA_WIDTH-1:0] in_energy,
    input  logic        [N_WIDTH-1:0]    in_n,
    output logic                         out_valid,
    output logic signed [DATA_WIDTH-1:0] out_mean,
    output logic        [N_WIDTH-1:0]    out_n,
    output logic                         out_div0,
    output logic                         busy,
    output logic                         overrun
);

    import energy_mean_divider_pkg::*;

    localparam int DW = DATA_WIDTH;
    localparam int NW = N_WIDTH;
    localparam logic [NW-1:0] L_OFF = NW'(N_OFFSET);

    state_t r_state;
    state_t w_next;

    logic          r_in_valid_d;
    logic          r_sign;
    logic          r_div0;
    logic [DW-1:0] r_mag;
    logic [NW-1:0] r_divisor;
    logic [DW-1:0] r_mean;
    logic [NW-1:0] r_n;
    logic          r_out_div0;
    logic          r_out_valid;
    logic          r_busy;
    logic          r_overrun;

    logic          w_req;
    logic          w_cap;
    logic          w_start;
    logic          w_fix;
    logic          w_done;
    logic          w_nle;
    logic [DW-1:0] w_abs;
    logic [DW-1:0] w_quo;
    logic [DW-1:0] w_signed_q;

    assign w_req = in_valid & ~r_in_valid_d;
    assign w_nle = (in_n <= L_OFF);

    // Unary minus on the most negative value wraps to 2^(DW-1),
    // which is exactly the unsigned magnitude wanted.
    assign w_abs = in_energy[DW-1] ? -in_energy : in_energy;

    assign w_signed_q = r_sign ? -w_quo : w_quo;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next  = r_state;
        w_cap   = 1'b0;
        w_start = 1'b0;
        w_fix   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    w_cap  = 1'b1;
                    w_next = S_LOAD;
                end
            end
            S_LOAD: begin
                w_start = 1'b1;
                w_next  = S_DIV;
            end
            S_DIV: begin
                if (w_done) begin
                    w_next = S_FIX;
                end
            end
            S_FIX: begin
                w_fix  = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_in_valid_d <= 1'b0;
            r_sign       <= 1'b0;
            r_div0       <= 1'b0;
            r_mag        <= '0;
            r_divisor    <= '0;
            r_mean       <= '0;
            r_n          <= '0;
            r_out_div0   <= 1'b0;
            r_out_valid  <= 1'b0;
            r_busy       <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_in_valid_d <= in_valid;
            r_overrun    <= w_req && (r_state != S_IDLE);
            r_out_valid  <= w_fix;
            if (w_cap) begin
                r_sign    <= in_energy[DW-1];
                r_mag     <= w_abs;
                r_div0    <= w_nle;
                r_divisor <= w_nle ? '0 : (in_n - L_OFF);
                r_busy    <= 1'b1;
            end else if (r_out_valid) begin
                r_busy <= 1'b0;
            end
            if (w_fix) begin
                r_mean     <= r_div0 ? '0 : w_signed_q;
                r_n        <= r_divisor;
                r_out_div0 <= r_div0;
            end
        end
    end

    seq_udiv #(
        .DW (DW),
        .NW (NW)
    ) u_div (
        .clk        (clk),
        .rst        (rst),
        .i_start    (w_start),
        .i_dividend (r_mag),
        .i_divisor  (r_divisor),
        .o_quotient (w_quo),
        .o_done     (w_done)
    );

    assign out_valid = r_out_valid;
    assign out_mean  = r_mean;
    assign out_n     = r_n;
    assign out_div0  = r_out_div0;
    assign busy      = r_busy;
    assign overrun   = r_overrun;

endmodule

// File: tb/tb_energy_mean_divider.sv
// Self-checking bench for energy_mean_divider: vector table + corner sequences.
// Expected results are queued at capture and popped when out_valid fires.
module tb_energy_mean_divider;

    localparam int LAT = 67;

    logic               clk;
    logic               rst;
    logic               in_valid;
    logic signed [63:0] in_energy;
    logic        [31:0] in_n;
    logic               out_valid;
    logic signed [63:0] out_mean;
    logic        [31:0] out_n;
    logic               out_div0;
    logic               busy;
    logic               overrun;

    energy_mean_divider dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_energy (in_energy),
        .in_n      (in_n),
        .out_valid (out_valid),
        .out_mean  (out_mean),
        .out_n     (out_n),
        .out_div0  (out_div0),
        .busy      (busy),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [63:0] e;
        logic [31:0] n;
        logic [63:0] m;
        logic [31:0] on;
        logic        d;
    } vec_t;

    typedef struct {
        logic [63:0] m;
        logic [31:0] on;
        logic        d;
        int          due;
    } exp_t;

    vec_t tbl[9];
    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    task automatic send(input logic [63:0] e, input logic [31:0] n,
                        input logic [63:0] m, input logic [31:0] on,
                        input logic d);
        exp_t x;
        @(negedge clk);
        in_valid  = 1'b1;
        in_energy = e;
        in_n      = n;
        @(negedge clk);
        in_valid = 1'b0;
        x.m   = m;
        x.on  = on;
        x.d   = d;
        x.due = cyc + LAT;
        sb.push_back(x);
        chk("busy_after_capture", {63'd0, busy}, 64'd1);
    endtask

    task automatic pop_cmp(input string tag);
        exp_t x;
        if (sb.size() == 0) begin
            chk({tag, "_unexpected_valid"}, 64'd1, 64'd0);
        end else begin
            x = sb.pop_front();
            chk({tag, "_mean"}, out_mean, x.m);
            chk({tag, "_n"}, {32'd0, out_n}, {32'd0, x.on});
            chk({tag, "_div0"}, {63'd0, out_div0}, {63'd0, x.d});
            chk({tag, "_latency"}, 64'(cyc), 64'(x.due));
            chk({tag, "_busy_at_valid"}, {63'd0, busy}, 64'd1);
        end
    endtask

    task automatic wait_result(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        if (!seen) begin
            chk({tag, "_timeout"}, 64'd0, 64'd1);
            sb.delete();
        end else begin
            pop_cmp(tag);
            @(negedge clk);
            chk({tag, "_valid_pulse"}, {63'd0, out_valid}, 64'd0);
            chk({tag, "_busy_after"}, {63'd0, busy}, 64'd0);
        end
    endtask

    task automatic quiet(input int ncyc, input string tag);
        int pulses;
        pulses = 0;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            if (out_valid) pulses++;
        end
        chk({tag, "_no_valid"}, 64'(pulses), 64'd0);
    endtask

    initial begin
        int pulses;
        int ovr;
        exp_t x;

        tbl[0] = '{64'd1000, 32'd11, 64'd100, 32'd10, 1'b0};
        tbl[1] = '{-64'd7, 32'd3, -64'd3, 32'd2, 1'b0};
        tbl[2] = '{64'd7, 32'd3, 64'd3, 32'd2, 1'b0};
        tbl[3] = '{64'd500, 32'd1, 64'd0, 32'd0, 1'b1};
        tbl[4] = '{64'd500, 32'd0, 64'd0, 32'd0, 1'b1};
        tbl[5] = '{64'h8000_0000_0000_0000, 32'd2,
                   64'h8000_0000_0000_0000, 32'd1, 1'b0};
        tbl[6] = '{64'h7FFF_FFFF_FFFF_FFFF, 32'd3,
                   64'h3FFF_FFFF_FFFF_FFFF, 32'd2, 1'b0};
        tbl[7] = '{-64'd1000, 32'd5, -64'd250, 32'd4, 1'b0};
        tbl[8] = '{64'd0, 32'd100, 64'd0, 32'd99, 1'b0};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_energy = '0;
        in_n      = '0;
        repeat (3) @(negedge clk);
        chk("rst_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_mean", out_mean, 64'd0);
        chk("rst_n", {32'd0, out_n}, 64'd0);
        chk("rst_div0", {63'd0, out_div0}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_overrun", {63'd0, overrun}, 64'd0);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            send(tbl[i].e, tbl[i].n, tbl[i].m, tbl[i].on, tbl[i].d);
            wait_result($sformatf("vec%0d", i));
        end

        // Level held high for 200 cycles: one request, one result.
        @(negedge clk);
        in_valid  = 1'b1;
        in_energy = 64'd1000;
        in_n      = 32'd11;
        pulses = 0;
        ovr    = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (i == 0) begin
                x.m = 64'd100; x.on = 32'd10; x.d = 1'b0;
                x.due = cyc + LAT;
                sb.push_back(x);
            end
            if (overrun) ovr++;
            if (out_valid) begin
                pulses++;
                pop_cmp("held");
            end
        end
        in_valid = 1'b0;
        chk("held_pulses", 64'(pulses), 64'd1);
        chk("held_overrun", 64'(ovr), 64'd0);
        sb.delete();
        quiet(5, "held_tail");

        // New edge 10 cycles after capture is dropped with overrun.
        send(64'd90, 32'd10, 64'd10, 32'd9, 1'b0);
        repeat (9) @(negedge clk);
        in_valid  = 1'b1;
        in_energy = 64'd5;
        in_n      = 32'd2;
        @(negedge clk);
        chk("ovr_pulse", {63'd0, overrun}, 64'd1);
        in_valid = 1'b0;
        @(negedge clk);
        chk("ovr_one_cycle", {63'd0, overrun}, 64'd0);
        wait_result("ovr_first");
        quiet(80, "ovr_dropped");

        // Request landing on the out_valid edge is dropped too.
        send(64'd7, 32'd3, 64'd3, 32'd2, 1'b0);
        repeat (LAT - 1) @(negedge clk);
        in_valid  = 1'b1;
        in_energy = 64'd100;
        in_n      = 32'd2;
        @(negedge clk);
        chk("edge_valid", {63'd0, out_valid}, 64'd1);
        chk("edge_overrun", {63'd0, overrun}, 64'd1);
        if (out_valid) pop_cmp("edge");
        else sb.delete();
        in_valid = 1'b0;
        @(negedge clk);
        chk("edge_busy_after", {63'd0, busy}, 64'd0);
        quiet(80, "edge_dropped");

        // Reset during DIV abandons the division and clears results.
        chk("pre_rst_mean_held", out_mean, 64'd3);
        send(64'd12345, 32'd6, 64'd2469, 32'd5, 1'b0);
        void'(sb.pop_back());
        repeat (29) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_mean", out_mean, 64'd0);
        chk("mid_rst_n", {32'd0, out_n}, 64'd0);
        chk("mid_rst_busy", {63'd0, busy}, 64'd0);
        chk("mid_rst_valid", {63'd0, out_valid}, 64'd0);
        quiet(80, "mid_rst");
        send(64'd90, 32'd10, 64'd10, 32'd9, 1'b0);
        wait_result("post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
